// File: rtl/rom_dl_sched_pkg.sv
// Shared definitions for the M62 ROM download scheduler: default region
// boundaries, the scheduler state encoding and the byte-address decoder.
package m62_dl_pkg;

  // Default region boundaries (byte addresses in the ioctl stream).
  localparam logic [24:0] P2_BASE_DEF   = 25'h30000;  // graphics, mirrored to port 2
  localparam logic [24:0] PROM_BASE_DEF = 25'hA0000;  // first PROM byte
  localparam logic [24:0] PROM_END_DEF  = 25'hA0920;  // one past the last PROM byte

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    FINISH
  } dl_state_e;

  // Where a downloaded byte goes; exactly one of p1/prom/drop is set,
  // p2 only ever appears together with p1.
  typedef struct packed {
    logic p1;
    logic p2;
    logic prom;
    logic drop;
  } region_t;

  function automatic region_t decode_region(
    input logic [24:0] addr,
    input logic [24:0] p2_base,
    input logic [24:0] prom_base,
    input logic [24:0] prom_end
  );
    region_t r;
    r = '0;
    if (addr < p2_base) begin
      r.p1 = 1'b1;
    end else if (addr < prom_base) begin
      r.p1 = 1'b1;
      r.p2 = 1'b1;
    end else if (addr < prom_end) begin
      r.prom = 1'b1;
    end else begin
      r.drop = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/rom_dl_sched_if.sv
// Toggle-handshake byte-write bundle towards the two SDRAM controller ports.
// The scheduler is the master (drives req/a/ds/d), the controller the slave.
interface rom_dl_sched_if;

  logic        port1_req;
  logic        port1_ack;
  logic [22:0] port1_a;
  logic [1:0]  port1_ds;
  logic [15:0] port1_d;

  logic        port2_req;
  logic        port2_ack;
  logic [22:0] port2_a;
  logic [1:0]  port2_ds;
  logic [15:0] port2_d;

  modport master (
    output port1_req, port1_a, port1_ds, port1_d,
    output port2_req, port2_a, port2_ds, port2_d,
    input  port1_ack, port2_ack
  );

  modport slave (
    input  port1_req, port1_a, port1_ds, port1_d,
    input  port2_req, port2_a, port2_ds, port2_d,
    output port1_ack, port2_ack
  );

endinterface

// File: rtl/rom_dl_sched_toggle_port.sv
// One SDRAM write port using a toggle handshake: each issue flips req and
// captures the write fields, which then stay put until ack catches up.
module toggle_port (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        issue_i,
  input  logic [22:0] a_i,
  input  logic [1:0]  ds_i,
  input  logic [15:0] d_i,
  input  logic        ack_i,
  output logic        req_o,
  output logic [22:0] a_o,
  output logic [1:0]  ds_o,
  output logic [15:0] d_o,
  output logic        busy_o
);

  logic        req_q;
  logic [22:0] a_q;
  logic [1:0]  ds_q;
  logic [15:0] d_q;

  // Flip req and capture the write fields on every issue.
  // NOTE: registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  // NOTE: the async reset clears req as well, so the controller sharing this
  // reset sees req==ack==0 afterwards and no stale request survives.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_q <= 1'b0;
      a_q   <= '0;
      ds_q  <= '0;
      d_q   <= '0;
    end else if (issue_i) begin
      req_q <= ~req_q;
      a_q   <= a_i;
      ds_q  <= ds_i;
      d_q   <= d_i;
    end
  end

  assign req_o  = req_q;
  assign a_o    = a_q;
  assign ds_o   = ds_q;
  assign d_o    = d_q;
  assign busy_o = req_q ^ ack_i;

endmodule

// File: rtl/rom_dl_sched.sv
// ROM download scheduler for the Irem M62 core. Turns the HPS ioctl byte
// stream into SDRAM port writes / PROM strobes, back-pressures the HPS while
// SDRAM writes are outstanding, and owns rom_loaded plus the game reset.
module rom_dl_sched
  import m62_dl_pkg::*;
#(
  parameter logic [24:0] P2_BASE    = P2_BASE_DEF,
  parameter logic [24:0] PROM_BASE  = PROM_BASE_DEF,
  parameter logic [24:0] PROM_END   = PROM_END_DEF,
  parameter logic [15:0] RST_CYCLES = 16'hFFFF
) (
  input  logic                  clk_sys,
  input  logic                  reset_n,
  input  logic                  ioctl_download,
  input  logic                  ioctl_wr,
  input  logic [24:0]           ioctl_addr,
  input  logic [7:0]            ioctl_dout,
  output logic                  ioctl_wait,
  rom_dl_sched_if.master        sdram,
  output logic                  prom_wr,
  output logic [11:0]           prom_addr,
  output logic [7:0]            prom_data,
  input  logic                  soft_reset,
  output logic                  rom_loaded,
  output logic                  game_reset
);

  dl_state_e   state_q, state_d;
  logic        wr_q, dl_q;
  logic [24:0] addr_q, addr_d;
  logic [7:0]  data_q, data_d;
  logic        skid_vld_q, skid_vld_d;
  logic [24:0] skid_addr_q, skid_addr_d;
  logic [7:0]  skid_data_q, skid_data_d;
  logic        overrun_q, overrun_d;       // sticky: a skid entry was overwritten
  logic        fin_pend_q, fin_pend_d;
  logic        wait_q, wait_d;
  logic        rom_loaded_q, rom_loaded_d;
  logic        prom_wr_q, prom_wr_d;
  logic [11:0] prom_addr_q, prom_addr_d;
  logic [7:0]  prom_data_q, prom_data_d;
  logic [15:0] rst_cnt_q, rst_cnt_d;

  logic        wr_edge, dl_fall, fin_now;
  logic        issue1, issue2, busy1, busy2;
  region_t     reg_new, reg_skid, reg_cur;
  logic [23:0] p2_off;
  logic [11:0] prom_off;

  assign wr_edge = ioctl_wr & ~wr_q & ioctl_download;
  assign dl_fall = dl_q & ~ioctl_download;
  assign fin_now = fin_pend_q | dl_fall;

  assign reg_new  = decode_region(ioctl_addr,  P2_BASE, PROM_BASE, PROM_END);
  assign reg_skid = decode_region(skid_addr_q, P2_BASE, PROM_BASE, PROM_END);
  assign reg_cur  = decode_region(addr_q,      P2_BASE, PROM_BASE, PROM_END);

  // Offsets only need the low bits: inside their regions the differences fit.
  assign p2_off   = addr_q[23:0] - P2_BASE[23:0];
  assign prom_off = addr_q[11:0] - PROM_BASE[11:0];

  toggle_port u_port1 (
    .clk     (clk_sys),
    .rst_n   (reset_n),
    .issue_i (issue1),
    .a_i     (addr_q[23:1]),
    .ds_i    ({addr_q[0], ~addr_q[0]}),
    .d_i     ({data_q, data_q}),
    .ack_i   (sdram.port1_ack),
    .req_o   (sdram.port1_req),
    .a_o     (sdram.port1_a),
    .ds_o    (sdram.port1_ds),
    .d_o     (sdram.port1_d),
    .busy_o  (busy1)
  );

  toggle_port u_port2 (
    .clk     (clk_sys),
    .rst_n   (reset_n),
    .issue_i (issue2),
    .a_i     (p2_off[23:1]),
    .ds_i    ({p2_off[0], ~p2_off[0]}),
    .d_i     ({data_q, data_q}),
    .ack_i   (sdram.port2_ack),
    .req_o   (sdram.port2_req),
    .a_o     (sdram.port2_a),
    .ds_o    (sdram.port2_ds),
    .d_o     (sdram.port2_d),
    .busy_o  (busy2)
  );

  // Scheduler state, latched byte, skid buffer and registered outputs.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      wr_q         <= 1'b0;
      dl_q         <= 1'b0;
      addr_q       <= '0;
      data_q       <= '0;
      skid_vld_q   <= 1'b0;
      skid_addr_q  <= '0;
      skid_data_q  <= '0;
      overrun_q    <= 1'b0;
      fin_pend_q   <= 1'b0;
      wait_q       <= 1'b0;
      rom_loaded_q <= 1'b0;
      prom_wr_q    <= 1'b0;
      prom_addr_q  <= '0;
      prom_data_q  <= '0;
    end else begin
      state_q      <= state_d;
      wr_q         <= ioctl_wr;
      dl_q         <= ioctl_download;
      addr_q       <= addr_d;
      data_q       <= data_d;
      skid_vld_q   <= skid_vld_d;
      skid_addr_q  <= skid_addr_d;
      skid_data_q  <= skid_data_d;
      overrun_q    <= overrun_d;
      fin_pend_q   <= fin_pend_d;
      wait_q       <= wait_d;
      rom_loaded_q <= rom_loaded_d;
      prom_wr_q    <= prom_wr_d;
      prom_addr_q  <= prom_addr_d;
      prom_data_q  <= prom_data_d;
    end
  end

  // Next-state logic: accept/skid bytes, issue writes, wait for acks, finish.
  // NOTE: every signal assigned here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    data_d      = data_q;
    skid_vld_d  = skid_vld_q;
    skid_addr_d = skid_addr_q;
    skid_data_d = skid_data_q;
    overrun_d   = overrun_q;
    fin_pend_d  = fin_now;
    wait_d      = wait_q;
    prom_wr_d   = 1'b0;
    prom_addr_d = prom_addr_q;
    prom_data_d = prom_data_q;
    issue1      = 1'b0;
    issue2      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (skid_vld_q) begin
          // A byte that arrived while busy goes first; a fresh edge refills the slot.
          addr_d      = skid_addr_q;
          data_d      = skid_data_q;
          wait_d      = reg_skid.p1;
          skid_vld_d  = wr_edge;
          skid_addr_d = wr_edge ? ioctl_addr : skid_addr_q;
          skid_data_d = wr_edge ? ioctl_dout : skid_data_q;
          state_d     = ISSUE;
        end else if (wr_edge) begin
          addr_d  = ioctl_addr;
          data_d  = ioctl_dout;
          wait_d  = reg_new.p1;
          state_d = ISSUE;
        end else if (fin_now) begin
          fin_pend_d = 1'b0;
          state_d    = FINISH;
        end
      end

      ISSUE: begin
        issue1 = reg_cur.p1;
        issue2 = reg_cur.p2;
        if (reg_cur.prom) begin
          prom_wr_d   = 1'b1;
          prom_addr_d = prom_off;
          prom_data_d = data_q;
        end
        wait_d  = reg_cur.p1;
        state_d = reg_cur.p1 ? WAIT : IDLE;
      end

      WAIT: begin
        // Each port is tracked on its own, so acks may arrive in any order.
        if (!busy1 && !busy2) begin
          wait_d = 1'b0;
          if (fin_now && !skid_vld_q && !wr_edge) begin
            fin_pend_d = 1'b0;
            state_d    = FINISH;
          end else begin
            state_d = IDLE;
          end
        end
      end

      FINISH: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // An edge while not idle is parked; a second one overwrites it.
    if (state_q != IDLE && wr_edge) begin
      skid_vld_d  = 1'b1;
      skid_addr_d = ioctl_addr;
      skid_data_d = ioctl_dout;
      if (skid_vld_q) begin
        overrun_d = 1'b1;
      end
    end
  end

  // rom_loaded is sticky and rises on the edge that enters FINISH.
  assign rom_loaded_d = rom_loaded_q | (state_d == FINISH);

  // Game reset stretcher: reload while any source is active, else count down.
  always_comb begin
    rst_cnt_d = rst_cnt_q;
    if (soft_reset || !rom_loaded_q || ioctl_download) begin
      rst_cnt_d = RST_CYCLES;
    end else if (rst_cnt_q != 16'd0) begin
      rst_cnt_d = rst_cnt_q - 16'd1;
    end
  end

  // Game reset counter register; starts full so the game is held in reset.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      rst_cnt_q <= RST_CYCLES;
    end else begin
      rst_cnt_q <= rst_cnt_d;
    end
  end

  assign ioctl_wait = wait_q;
  assign prom_wr    = prom_wr_q;
  assign prom_addr  = prom_addr_q;
  assign prom_data  = prom_data_q;
  assign rom_loaded = rom_loaded_q;
  assign game_reset = (rst_cnt_q != 16'd0);

endmodule

// File: tb/tb_rom_dl_sched.sv
// Scoreboard bench for rom_dl_sched: stimulus pushes expected SDRAM/PROM
// writes computed from the address map, a monitor pops and compares them.
module tb_rom_dl_sched;

  typedef struct {
    logic [22:0] a;
    logic [1:0]  ds;
    logic [15:0] d;
  } sd_exp_t;

  typedef struct {
    logic [11:0] a;
    logic [7:0]  d;
  } prom_exp_t;

  logic        clk_sys = 1'b0;
  logic        reset_n;
  logic        ioctl_download;
  logic        ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic        ioctl_wait;
  logic        prom_wr;
  logic [11:0] prom_addr;
  logic [7:0]  prom_data;
  logic        soft_reset;
  logic        rom_loaded;
  logic        game_reset;

  rom_dl_sched_if sd ();

  rom_dl_sched #(
    .RST_CYCLES(16'd16)
  ) dut (
    .clk_sys        (clk_sys),
    .reset_n        (reset_n),
    .ioctl_download (ioctl_download),
    .ioctl_wr       (ioctl_wr),
    .ioctl_addr     (ioctl_addr),
    .ioctl_dout     (ioctl_dout),
    .ioctl_wait     (ioctl_wait),
    .sdram          (sd),
    .prom_wr        (prom_wr),
    .prom_addr      (prom_addr),
    .prom_data      (prom_data),
    .soft_reset     (soft_reset),
    .rom_loaded     (rom_loaded),
    .game_reset     (game_reset)
  );

  always #5 clk_sys = ~clk_sys;

  int n_checks = 0;
  int n_errors = 0;

  sd_exp_t   q1[$];
  sd_exp_t   q2[$];
  prom_exp_t qp[$];

  int unsigned p1_delay = 0;
  int unsigned p2_delay = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: where a byte should land, straight from the address map.
  task automatic model_push(input logic [24:0] a, input logic [7:0] d,
                            output bit e1, output bit e2, output bit ep);
    int unsigned ai;
    int unsigned off;
    ai = a;
    e1 = (ai < 'hA0000);
    e2 = (ai >= 'h30000) && (ai < 'hA0000);
    ep = (ai >= 'hA0000) && (ai < 'hA0920);
    if (e1) q1.push_back('{a: 23'(ai / 2), ds: (ai % 2 == 1) ? 2'b10 : 2'b01, d: {d, d}});
    if (e2) begin
      off = ai - 'h30000;
      q2.push_back('{a: 23'(off / 2), ds: (off % 2 == 1) ? 2'b10 : 2'b01, d: {d, d}});
    end
    if (ep) qp.push_back('{a: 12'(ai - 'hA0000), d: d});
  endtask

  // SDRAM controller stand-ins: ack each toggle after a programmable delay.
  initial begin
    forever begin
      @(negedge clk_sys);
      if (sd.port1_req !== sd.port1_ack) begin
        repeat (p1_delay) @(posedge clk_sys);
        #2 sd.port1_ack = sd.port1_req;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk_sys);
      if (sd.port2_req !== sd.port2_ack) begin
        repeat (p2_delay) @(posedge clk_sys);
        #2 sd.port2_ack = sd.port2_req;
      end
    end
  end

  // Monitor: pop an expectation on every req toggle / prom_wr, and check
  // that the write fields hold still while a request is outstanding.
  logic    l1 = 1'b0, l2 = 1'b0;
  sd_exp_t h1, h2;
  initial begin
    sd_exp_t   e;
    prom_exp_t pe;
    forever begin
      @(negedge clk_sys);
      if (!reset_n) begin
        l1 = 1'b0;
        l2 = 1'b0;
      end else begin
        if (sd.port1_req !== l1) begin
          l1 = sd.port1_req;
          check("p1_toggle_expected", q1.size() != 0, 1);
          if (q1.size() != 0) begin
            e = q1.pop_front();
            h1 = e;
            check("p1_a", sd.port1_a, e.a);
            check("p1_ds", sd.port1_ds, e.ds);
            check("p1_d", sd.port1_d, e.d);
          end
        end else if (sd.port1_req !== sd.port1_ack) begin
          check("p1_a_stable", sd.port1_a, h1.a);
          check("p1_d_stable", {sd.port1_ds, sd.port1_d}, {h1.ds, h1.d});
        end
        if (sd.port2_req !== l2) begin
          l2 = sd.port2_req;
          check("p2_toggle_expected", q2.size() != 0, 1);
          if (q2.size() != 0) begin
            e = q2.pop_front();
            h2 = e;
            check("p2_a", sd.port2_a, e.a);
            check("p2_ds", sd.port2_ds, e.ds);
            check("p2_d", sd.port2_d, e.d);
          end
        end else if (sd.port2_req !== sd.port2_ack) begin
          check("p2_a_stable", sd.port2_a, h2.a);
          check("p2_d_stable", {sd.port2_ds, sd.port2_d}, {h2.ds, h2.d});
        end
        if (prom_wr) begin
          check("prom_wr_expected", qp.size() != 0, 1);
          if (qp.size() != 0) begin
            pe = qp.pop_front();
            check("prom_addr", prom_addr, pe.a);
            check("prom_data", prom_data, pe.d);
          end
        end
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_p1_req"}, sd.port1_req, 0);
    check({tag, "_p2_req"}, sd.port2_req, 0);
    check({tag, "_p1_fields"}, {sd.port1_a, sd.port1_ds, sd.port1_d}, 0);
    check({tag, "_p2_fields"}, {sd.port2_a, sd.port2_ds, sd.port2_d}, 0);
    check({tag, "_prom"}, {prom_wr, prom_addr, prom_data}, 0);
    check({tag, "_ioctl_wait"}, ioctl_wait, 0);
    check({tag, "_rom_loaded"}, rom_loaded, 0);
    check({tag, "_game_reset"}, game_reset, 1);
  endtask

  // Pulse one byte from idle (call at posedge+1) and check the issue timing.
  task automatic pulse_byte(input logic [24:0] a, input logic [7:0] d);
    bit   e1, e2, ep;
    logic r1, r2;
    model_push(a, d, e1, e2, ep);
    r1 = sd.port1_req;
    r2 = sd.port2_req;
    ioctl_addr = a;
    ioctl_dout = d;
    ioctl_wr   = 1'b1;
    @(posedge clk_sys); #1;
    ioctl_wr = 1'b0;
    check("wait_after_accept", ioctl_wait, e1);
    check("p1_req_before_issue", sd.port1_req, r1);
    check("p2_req_before_issue", sd.port2_req, r2);
    @(posedge clk_sys); #1;
    check("p1_req_at_issue", sd.port1_req, r1 ^ e1);
    check("p2_req_at_issue", sd.port2_req, r2 ^ e2);
    check("prom_wr_at_issue", prom_wr, ep);
    if (!e1) check("wait_low_no_sdram", ioctl_wait, 0);
  endtask

  // Raw wr pulse with no timing checks, used to provoke the skid path.
  task automatic pulse_raw(input logic [24:0] a, input logic [7:0] d, input bit expect_it);
    bit e1, e2, ep;
    if (expect_it) model_push(a, d, e1, e2, ep);
    ioctl_addr = a;
    ioctl_dout = d;
    ioctl_wr   = 1'b1;
    @(posedge clk_sys); #1;
    ioctl_wr = 1'b0;
    @(posedge clk_sys); #1;
  endtask

  // Wait until all expected writes were seen and both ports are quiet.
  task automatic drain(input string tag);
    int stable = 0;
    int n = 0;
    while (stable < 3 && n < 2000) begin
      @(posedge clk_sys); #1;
      n++;
      if (q1.size() == 0 && q2.size() == 0 && qp.size() == 0 && !ioctl_wait &&
          sd.port1_req === sd.port1_ack && sd.port2_req === sd.port2_ack)
        stable++;
      else
        stable = 0;
    end
    check({tag, "_drained"}, stable >= 3, 1);
  endtask

  task automatic send_byte(input logic [24:0] a, input logic [7:0] d);
    pulse_byte(a, d);
    drain("send");
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: run still active at %0t, expected completion", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    logic [24:0] ra;
    logic [24:0] bounds [6];

    reset_n        = 1'b0;
    ioctl_download = 1'b1;
    ioctl_wr       = 1'b0;
    ioctl_addr     = '0;
    ioctl_dout     = '0;
    soft_reset     = 1'b0;
    sd.port1_ack   = 1'b0;
    sd.port2_ack   = 1'b0;
    repeat (2) @(posedge clk_sys);
    #1;
    check_reset_outputs("por");
    @(posedge clk_sys); #1;
    reset_n = 1'b1;
    @(posedge clk_sys); #1;

    // Port 1 only, wait held until the (late) ack.
    p1_delay = 6;
    pulse_byte(25'h00003, 8'h5A);
    n = 0;
    while (sd.port1_ack !== sd.port1_req && n < 100) begin
      check("t1_wait_held", ioctl_wait, 1);
      @(posedge clk_sys); #1;
      n++;
    end
    check("t1_wait_released", ioctl_wait, 0);
    drain("t1");

    // Both ports; port 2 acks 5 cycles before port 1.
    p1_delay = 8;
    p2_delay = 3;
    pulse_byte(25'h30004, 8'hC3);
    n = 0;
    while (sd.port2_ack !== sd.port2_req && n < 100) begin
      @(posedge clk_sys); #1;
      n++;
    end
    check("t2_wait_after_p2_ack", ioctl_wait, 1);
    check("t2_p1_still_pending", sd.port1_req ^ sd.port1_ack, 1);
    n = 0;
    while (sd.port1_ack !== sd.port1_req && n < 100) begin
      @(posedge clk_sys); #1;
      n++;
    end
    check("t2_wait_after_p1_ack", ioctl_wait, 0);
    drain("t2");

    // PROM byte: one strobe, no back-pressure.
    pulse_byte(25'hA0305, 8'h0F);
    @(posedge clk_sys); #1;
    check("t3_prom_wr_one_cycle", prom_wr, 0);
    check("t3_wait_low", ioctl_wait, 0);
    drain("t3");

    // Dropped byte followed at once by a port-1 byte.
    pulse_byte(25'hA0920, 8'h77);
    pulse_byte(25'h2FFFF, 8'h11);
    drain("t4");

    // Region boundaries with random data and ack delays.
    bounds[0] = 25'h30000;
    bounds[1] = 25'h9FFFF;
    bounds[2] = 25'hA0000;
    bounds[3] = 25'hA091F;
    bounds[4] = 25'h1FFFFFF;
    bounds[5] = 25'h0;
    for (int i = 0; i < 6; i++) begin
      p1_delay = $urandom_range(0, 4);
      p2_delay = $urandom_range(0, 4);
      send_byte(bounds[i], 8'($urandom));
    end

    // Random bytes across all regions.
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 3))
        0:       ra = 25'($urandom_range(0, 'h2FFFF));
        1:       ra = 25'($urandom_range('h30000, 'h9FFFF));
        2:       ra = 25'($urandom_range('hA0000, 'hA091F));
        default: ra = 25'($urandom_range('hA0920, 'h1FFFFFF));
      endcase
      p1_delay = $urandom_range(0, 4);
      p2_delay = $urandom_range(0, 4);
      send_byte(ra, 8'($urandom));
    end

    // Two edges while busy: the second overwrites the first in the skid slot.
    p1_delay = 6;
    pulse_raw(25'h00200, 8'h21, 1'b1);
    pulse_raw(25'h00202, 8'h22, 1'b0);
    pulse_raw(25'h00204, 8'h23, 1'b1);
    drain("skid");
    check("skid_overrun_flag", dut.overrun_q, 1);

    // Download falls during WAIT: rom_loaded one cycle after the ack,
    // game_reset released 16 cycles after that.
    check("rom_loaded_before", rom_loaded, 0);
    p1_delay = 6;
    pulse_byte(25'h00400, 8'h44);
    ioctl_download = 1'b0;
    n = 0;
    while (sd.port1_ack !== sd.port1_req && n < 100) begin
      check("fin_rom_loaded_low", rom_loaded, 0);
      @(posedge clk_sys); #1;
      n++;
    end
    check("fin_rom_loaded_high", rom_loaded, 1);
    check("fin_game_reset_held", game_reset, 1);
    for (int i = 1; i <= 16; i++) begin
      @(posedge clk_sys); #1;
      check("fin_game_reset_count", game_reset, (i < 16) ? 1 : 0);
    end
    drain("fin");

    // Soft reset pulse reloads the stretcher.
    soft_reset = 1'b1;
    @(posedge clk_sys); #1;
    soft_reset = 1'b0;
    check("soft_game_reset_reload", game_reset, 1);
    for (int i = 1; i <= 16; i++) begin
      @(posedge clk_sys); #1;
      check("soft_game_reset_count", game_reset, (i < 16) ? 1 : 0);
    end
    check("soft_rom_loaded_sticky", rom_loaded, 1);

    // Asynchronous reset in the middle of a WAIT.
    ioctl_download = 1'b1;
    @(posedge clk_sys); #1;
    p1_delay = 30;
    pulse_byte(25'h00100, 8'hAB);
    #3 reset_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    q1.delete();
    q2.delete();
    qp.delete();
    sd.port1_ack = 1'b0;
    sd.port2_ack = 1'b0;
    repeat (2) @(posedge clk_sys);
    #1 reset_n = 1'b1;
    repeat (40) @(posedge clk_sys);
    #1;
    p1_delay = 2;
    p2_delay = 1;
    send_byte(25'h3FFFE, 8'h99);

    check("end_q1_empty", q1.size(), 0);
    check("end_q2_empty", q2.size(), 0);
    check("end_qp_empty", qp.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/rom_dl_sched.md
# rom_dl_sched

ROM download scheduler between the HPS ioctl stream and the dual-port SDRAM controller plus on-chip PROM/DIP stores of the Irem M62 core. Decodes each downloaded byte into a region, issues toggle-handshake byte writes to SDRAM port 1 and/or port 2, strobes PROM writes, and back-pressures the HPS while any SDRAM write is outstanding. Also owns `rom_loaded` and the game reset stretcher, replacing the ad-hoc download/reset logic in the top level.

## Interface
Parameters:
- `P2_BASE`, 25'h30000, first byte address also mirrored to port 2 (graphics).
- `PROM_BASE`, 25'hA0000, first PROM byte address.
- `PROM_END`, 25'hA0920, one past the last PROM byte.
- `RST_CYCLES`, 16'hFFFF, length of the game reset after the last reset source clears.

Ports:
- `clk_sys`  in  1  system clock.
- `reset_n`  in  1  asynchronous active-low reset.
- `ioctl_download`  in  1  download active, index-0 qualified by the caller.
- `ioctl_wr`  in  1  byte valid; level, edge-detected internally.
- `ioctl_addr`  in  25  byte address.
- `ioctl_dout`  in  8  byte data.
- `ioctl_wait`  out  1  HPS must hold the next byte.
- `port1_req` / `port2_req`  out  1  toggle request.
- `port1_ack` / `port2_ack`  in  1  toggle ack; equal to req means done.
- `port1_a` / `port2_a`  out  23  word address.
- `port1_ds` / `port2_ds`  out  2  byte strobes {hi,lo}.
- `port1_d` / `port2_d`  out  16  data, byte duplicated.
- `prom_wr`  out  1  one-cycle PROM write strobe.
- `prom_addr`  out  12  byte offset from `PROM_BASE`.
- `prom_data`  out  8  PROM byte.
- `soft_reset`  in  1  OSD reset or button, level.
- `rom_loaded`  out  1  sticky, set after the first complete download.
- `game_reset`  out  1  active-high reset for the game core.

## Operation
- Accept a byte on the rising edge of `ioctl_wr` (registered compare with the previous value) while `ioctl_download=1`. Ignore edges when the download is inactive.
- Decode the latched byte address A:
  - A < `P2_BASE`: port 1 only.
  - `P2_BASE` ≤ A < `PROM_BASE`: port 1 at A, and port 2 at A−`P2_BASE`.
  - `PROM_BASE` ≤ A < `PROM_END`: `prom_wr` only, no SDRAM access.
  - A ≥ `PROM_END`: dropped, no side effect.
- SDRAM write fields: address `A[23:1]`, `ds={A[0],~A[0]}`, data `{dout,dout}`. Port 2 uses the offset address.
- FSM states:
  - IDLE: on an accepted byte, latch address and data, go to ISSUE.
  - ISSUE, one cycle: toggle the required req(s), or pulse `prom_wr`; go to WAIT for SDRAM, IDLE for PROM or dropped bytes.
  - WAIT: stay until every issued port has req==ack, then IDLE.
  - FINISH: entered from IDLE when `ioctl_download` has fallen and nothing is pending. Sets `rom_loaded`, then IDLE.
- A download fall seen while in ISSUE or WAIT is remembered (flag) and FINISH follows completion.
- Acks arriving out of order between ports are fine; each port is tracked independently.
- `game_reset` counter: load `RST_CYCLES` while `soft_reset | ~rom_loaded | ioctl_download`, else decrement to 0. `game_reset = (count != 0)`.

## Timing
- Reset values:
  - req, a, ds, d all 0.
  - `prom_wr` 0, `prom_addr` 0, `prom_data` 0.
  - `ioctl_wait` 0, `rom_loaded` 0.
  - `game_reset` 1, count = `RST_CYCLES`.
- Byte accept to req toggle: 2 cycles (edge detect, then ISSUE). `prom_wr` lands at the same cycle as the toggle would.
- `ioctl_wait` is registered: 1 from the cycle after accept until the return to IDLE; 0 for PROM and dropped bytes after ISSUE.
- Outputs a/ds/d are stable from the toggle until the matching ack.
- A new `ioctl_wr` edge while not IDLE is a protocol violation; it is captured in a 1-deep skid register and processed next. A second violation overwrites it and sets an internal sticky `overrun` debug bit.
- `game_reset` deasserts exactly `RST_CYCLES` cycles after the last cycle its load condition was true.
- `reset_n` mid-transfer aborts the transfer. req returns to 0, so the SDRAM controller must be reset with it (same `reset_n` source).

## Structure
- Package `m62_dl_pkg`: region base constants, the state enum `{IDLE,ISSUE,WAIT,FINISH}`, and a region-decode function returning `{p1,p2,prom,drop}`.
- Sub-module `toggle_port`, instantiated twice: holds req, compares ack, latches a/ds/d, exposes `busy`.

## Test plan
- Byte 0x5A at A=0x00003 → port1 toggles once with a=0x000001, ds=2'b10, d=0x5A5A; port2 unchanged; `ioctl_wait` high until ack.
- Byte at A=0x30004 → both ports toggle the same cycle; port2_a=0x000002, ds=2'b01. Ack port2 5 cycles before port1 → wait drops only after port1_ack.
- Byte 0x0F at A=0xA0305 → `prom_wr` one cycle, prom_addr=0x305, prom_data=0x0F; no req toggle; `ioctl_wait` stays 0.
- A=0xA0920 → no req, no `prom_wr`, FSM back in IDLE in 2 cycles.
- Download falls while WAIT is pending → `rom_loaded` rises 1 cycle after the final ack. With `RST_CYCLES`=16, `game_reset` falls exactly 16 cycles later; `soft_reset` pulse → reloads and holds for 16 more.
- `reset_n` low during WAIT → all outputs at reset values the same cycle (async); `rom_loaded`=0, `game_reset`=1.
